// File: rtl/hazard_pkg.sv
// Shared types and constants for the operand-bypass / load-use interlock block.
package hazard_pkg;

    localparam int RA_W_MAX = 8;
    localparam int RDY_W    = 4;

    localparam int SEL_REGFILE = 0;
    localparam int SEL_MEM     = 2;
    localparam int SEL_WB      = 3;

    localparam int LOAD_RDY_DEF = 2;
    localparam int ALU_RDY_DEF  = 1;

    // rd is held at the widest supported register width; narrower cores zero-extend
    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic [RDY_W-1:0]    rdy;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{1'b0, {RA_W_MAX{1'b0}}, {RDY_W{1'b0}}};

endpackage

// File: rtl/hazard_forward_unit_fwd_port_match.sv
// Youngest-first scoreboard lookup for one read operand: hit, load-use hazard and bypass select.
module fwd_port_match
    import hazard_pkg::*;
#(
    parameter int RA_W    = 3,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = 2,
    parameter int ZERO_HW = 1
) (
    input  sb_entry_t [DEPTH:1] ent,
    input  logic [RA_W-1:0]     rs,
    input  logic                used,
    output logic                hit,
    output logic                hazard,
    output logic [SEL_W-1:0]    next_sel
);

    logic rs_zero_s;

    assign rs_zero_s = (ZERO_HW != 0) && (rs == {RA_W{1'b0}});

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        hit      = 1'b0;
        hazard   = 1'b0;
        next_sel = SEL_W'(SEL_REGFILE);
        for (int k = DEPTH; k >= 1; k--) begin
            logic m;
            m        = used && !rs_zero_s && ent[k].valid && (ent[k].rd == RA_W_MAX'(rs));
            hit      = hit | m;
            hazard   = m ? (k < int'(ent[k].rdy)) : hazard;
            next_sel = m ? ((k == DEPTH) ? SEL_W'(SEL_REGFILE) : SEL_W'(k + 1)) : next_sel;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Multi-stage operand bypass and load-use interlock: scoreboard shift register,
// stall/accept decision, registered EX bypass selects and a saturating stall counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int RA_W     = 3,
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = LOAD_RDY_DEF,
    parameter int ALU_RDY  = ALU_RDY_DEF,
    parameter int ZERO_HW  = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [NUM_RD*RA_W-1:0]  id_rs,
    input  logic [NUM_RD-1:0]       id_rs_used,
    input  logic [RA_W-1:0]         id_rd,
    input  logic                    id_regwrite,
    input  logic                    id_is_load,
    input  logic                    flush,
    output logic                    id_accept,
    output logic                    stall,
    output logic [NUM_RD*SEL_W-1:0] fwd_sel,
    output logic [CNT_W-1:0]        stall_count
);

    sb_entry_t [DEPTH:1]     ent_q, ent_d;
    sb_entry_t               new_ent_s;
    logic [NUM_RD-1:0]       hit_s, haz_s;
    logic [NUM_RD*SEL_W-1:0] next_sel_s, fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]        stall_count_q, stall_count_d;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_match #(
            .RA_W    (RA_W),
            .DEPTH   (DEPTH),
            .SEL_W   (SEL_W),
            .ZERO_HW (ZERO_HW)
        ) u_match (
            .ent      (ent_q),
            .rs       (id_rs[p*RA_W +: RA_W]),
            .used     (id_rs_used[p]),
            .hit      (hit_s[p]),
            .hazard   (haz_s[p]),
            .next_sel (next_sel_s[p*SEL_W +: SEL_W])
        );
    end

    // Interlock decision, scoreboard advance, select and counter next-state
    always_comb begin
        stall     = id_valid & ~flush & (|(hit_s & haz_s));
        id_accept = id_valid & ~flush & ~stall;

        new_ent_s       = SB_BUBBLE;
        new_ent_s.valid = id_accept & id_regwrite &
                          ~((ZERO_HW != 0) && (id_rd == {RA_W{1'b0}}));
        new_ent_s.rd    = RA_W_MAX'(id_rd);
        new_ent_s.rdy   = id_is_load ? RDY_W'(LOAD_RDY) : RDY_W'(ALU_RDY);

        ent_d    = ent_q;
        ent_d[1] = new_ent_s.valid ? new_ent_s : SB_BUBBLE;
        // A flush also kills the instruction currently in EX as it moves on
        for (int k = 2; k <= DEPTH; k++) begin
            ent_d[k] = ((k == 2) && flush) ? SB_BUBBLE : ent_q[k-1];
        end

        fwd_sel_d = id_accept ? next_sel_s : {(NUM_RD*SEL_W){1'b0}};

        stall_count_d = (stall && (stall_count_q != {CNT_W{1'b1}}))
                      ? stall_count_q + CNT_W'(1) : stall_count_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q         <= {DEPTH{SB_BUBBLE}};
            fwd_sel_q     <= {(NUM_RD*SEL_W){1'b0}};
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            ent_q         <= ent_d;
            fwd_sel_q     <= fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_sel     = fwd_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: the driver queues expected EX bypass selects, a monitor pops and compares them.
module tb_hazard_forward_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        id_valid, id_regwrite, id_is_load, flush;
    logic [5:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [2:0]  id_rd;
    logic        id_accept, stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_count;

    logic        b_id_valid, b_id_regwrite, b_id_is_load, b_flush;
    logic [5:0]  b_id_rs;
    logic [1:0]  b_id_rs_used;
    logic [2:0]  b_id_rd;
    logic        b_id_accept, b_stall;
    logic [5:0]  b_fwd_sel;
    logic [1:0]  b_stall_count;

    logic [3:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
        .id_accept(id_accept), .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    // Deep load latency and a 2-bit counter give five back-to-back stalls that saturate
    hazard_forward_unit #(.DEPTH(7), .LOAD_RDY(6), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(b_id_valid), .id_rs(b_id_rs), .id_rs_used(b_id_rs_used),
        .id_rd(b_id_rd), .id_regwrite(b_id_regwrite), .id_is_load(b_id_is_load), .flush(b_flush),
        .id_accept(b_id_accept), .stall(b_stall), .fwd_sel(b_fwd_sel), .stall_count(b_stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rs0, input logic u0,
                         input logic [2:0] rs1, input logic u1, input logic [2:0] rd,
                         input logic we, input logic ld, input logic fl,
                         input logic es, input logic ea, input logic [1:0] s0,
                         input logic [1:0] s1, input string name);
        @(negedge clk);
        id_valid    = v;
        id_rs       = {rs1, rs0};
        id_rs_used  = {u1, u0};
        id_rd       = rd;
        id_regwrite = we;
        id_is_load  = ld;
        flush       = fl;
        #1;
        chk({name, " stall"}, 32'(stall), 32'(es));
        chk({name, " accept"}, 32'(id_accept), 32'(ea));
        exp_q.push_back(ea ? {s1, s0} : 4'b0000);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 2'd0, 2'd0, "idle");
    endtask

    // Monitor: the registered select is presented the cycle after each driven decode cycle
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fwd_sel", 32'(fwd_sel), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rs = 6'd0; id_rs_used = 2'b00; id_rd = 3'd0;
        id_regwrite = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        b_id_valid = 1'b0; b_id_rs = 6'd0; b_id_rs_used = 2'b00; b_id_rd = 3'd0;
        b_id_regwrite = 1'b0; b_id_is_load = 1'b0; b_flush = 1'b0;
        #12;
        chk("rst fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst stall_count", 32'(stall_count), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst b_stall_count", 32'(b_stall_count), 32'd0);
        #1 rst = 1'b0;

        // ALU producer then immediate consumer: bypass from MEM
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, "alu_r1");
        drive(1, 1, 1, 0, 0, 3, 0, 0, 0, 0, 1, 2'(SEL_MEM), 0, "use_r1");

        // Load-use: one stall, then bypass from WB
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 0, 0, "load_r2");
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "lu_stall");
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'(SEL_WB), 0, "lu_go");
        chk("stall_count after load-use", 32'(stall_count), 32'd1);

        // Load, independent ALU, consumer of both on separate operands
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 0, 0, "load_r2b");
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, 0, "alu_r7");
        drive(1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 1, 2'(SEL_MEM), 2'(SEL_WB), "dual_use");

        // Two producers of r4: the younger wins
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, "alu_r4_old");
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, "alu_r4_young");
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'(SEL_MEM), 0, "young_r4");

        // Producer at the last tracked stage reads through the register file
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, "alu_r5");
        idle();
        idle();
        drive(1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, "depth_r5");

        // Writes to r0 are never tracked
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, "load_r0");
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "use_r0");

        // Flush during a load-use hazard drops both decode and the load in EX
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, "load_r3");
        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "flush_lu");
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "after_flush");
        chk("stall_count held on flush", 32'(stall_count), 32'd1);

        // Reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, "alu_r5b");
        drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 1, 2'(SEL_MEM), 0, "load_r6");
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_stall");
        #2;
        rst = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("mid-stall rst fwd_sel", 32'(fwd_sel), 32'd0);
        chk("mid-stall rst stall_count", 32'(stall_count), 32'd0);
        chk("mid-stall rst stall", 32'(stall), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "post_rst");
        idle();

        // Five consecutive stalls on the 2-bit counter instance
        @(negedge clk);
        b_id_valid = 1'b1; b_id_rd = 3'd1; b_id_regwrite = 1'b1; b_id_is_load = 1'b1;
        #1 chk("b load accept", 32'(b_id_accept), 32'd1);
        @(negedge clk);
        b_id_rd = 3'd0; b_id_regwrite = 1'b0; b_id_is_load = 1'b0;
        b_id_rs = 6'd1; b_id_rs_used = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1 chk("b stall", 32'(b_stall), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("b released stall", 32'(b_stall), 32'd0);
        chk("b released accept", 32'(b_id_accept), 32'd1);
        chk("b stall_count saturated", 32'(b_stall_count), 32'd3);
        @(posedge clk);
        #2 chk("b fwd_sel deep", 32'(b_fwd_sel), 32'd7);
        b_id_valid = 1'b0;

        @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
